// File: rtl/data_pack_if.sv
// Handshake/bus bundle for data_pack: upstream word/count/flush in, packed words out.
interface data_pack_if #(
  parameter int UNIT = 4,
  parameter int NU   = 2
);
  localparam int DW = UNIT * NU;
  localparam int CW = $clog2(NU + 1);

  logic          start;
  logic [DW-1:0] data_in;
  logic [CW-1:0] cnt;
  logic          flush;
  logic          ready;
  logic [DW-1:0] data_o;
  logic          data_en;
  logic [CW-1:0] data_cnt;
  logic [CW-1:0] res_cnt;

  modport master (output start, data_in, cnt, flush,
                  input  ready, data_o, data_en, data_cnt, res_cnt);
  modport slave  (input  start, data_in, cnt, flush,
                  output ready, data_o, data_en, data_cnt, res_cnt);
endinterface

// File: rtl/data_pack.sv
// Packs variable-count units LSB-first into full words, with residue carry and flush.
module data_pack #(
  parameter int UNIT = 4,
  parameter int NU   = 2
) (
  input  logic        clk,
  input  logic        reset,
  data_pack_if.slave  bus
);
  localparam int DW = UNIT * NU;
  localparam int CW = $clog2(NU + 1);
  localparam int TW = CW + 1;
  localparam logic [CW-1:0] NU_C = CW'(NU);
  localparam logic [TW-1:0] NU_T = TW'(NU);

  typedef enum logic [1:0] {EMPTY, PART, FLUSH_PEND} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] res_q, res_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          den_q, den_d;

  logic [CW-1:0]   eff;
  logic [DW-1:0]   nw;
  logic [2*DW-1:0] comb;
  logic [TW-1:0]   total;

  // New units are masked to the clamped count, then appended above the residue.
  always_comb begin
    eff = '0;
    if (bus.start) eff = (bus.cnt > NU_C) ? NU_C : bus.cnt;
    nw = '0;
    for (int i = 0; i < NU; i++)
      if (CW'(i) < eff) nw[i*UNIT +: UNIT] = bus.data_in[i*UNIT +: UNIT];
    comb  = {{DW{1'b0}}, res_q} | ({{DW{1'b0}}, nw} << (UNIT * int'(rcnt_q)));
    total = TW'(rcnt_q) + TW'(eff);
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    dout_d  = dout_q;
    dcnt_d  = dcnt_q;
    den_d   = 1'b0;
    case (state_q)
      FLUSH_PEND: begin
        den_d   = 1'b1;
        dout_d  = res_q;
        dcnt_d  = rcnt_q;
        res_d   = '0;
        rcnt_d  = '0;
        state_d = EMPTY;
      end
      default: begin
        if (bus.flush && total <= NU_T) begin
          if (total != '0) begin
            den_d  = 1'b1;
            dout_d = comb[DW-1:0];
            dcnt_d = CW'(total);
          end
          res_d   = '0;
          rcnt_d  = '0;
          state_d = EMPTY;
        end else if (total >= NU_T) begin
          den_d   = 1'b1;
          dout_d  = comb[DW-1:0];
          dcnt_d  = NU_C;
          res_d   = comb[2*DW-1:DW];
          rcnt_d  = CW'(total - NU_T);
          // A flush that overflows one word leaves a remainder for the next cycle.
          if (bus.flush)            state_d = FLUSH_PEND;
          else if (total == NU_T)   state_d = EMPTY;
          else                      state_d = PART;
        end else begin
          res_d   = comb[DW-1:0];
          rcnt_d  = CW'(total);
          state_d = (total == '0) ? EMPTY : PART;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      res_q   <= '0;
      rcnt_q  <= '0;
      dout_q  <= '0;
      dcnt_q  <= '0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      dout_q  <= dout_d;
      dcnt_q  <= dcnt_d;
      den_q   <= den_d;
    end
  end

  assign bus.ready    = (state_q != FLUSH_PEND);
  assign bus.data_o   = dout_q;
  assign bus.data_en  = den_q;
  assign bus.data_cnt = dcnt_q;
  assign bus.res_cnt  = rcnt_q;
endmodule

// File: tb/tb_data_pack.sv
// Bench for data_pack: directed vectors plus random traffic against a unit-queue model.
module tb_data_pack;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_pack_if #(.UNIT(4), .NU(2)) a ();
  data_pack_if #(.UNIT(4), .NU(4)) b ();

  data_pack #(.UNIT(4), .NU(2)) dut_a (.clk(clk), .reset(reset), .bus(a));
  data_pack #(.UNIT(4), .NU(4)) dut_b (.clk(clk), .reset(reset), .bus(b));

  // Model state: queue of held 4-bit units, pending-remainder flag, expected outputs.
  int unsigned mq[$];
  bit          mpend;
  logic [7:0]  e_do;
  logic [1:0]  e_cnt;
  bit          e_en;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic emit(int k);
    e_do = '0;
    for (int i = 0; i < k; i++) e_do |= 8'(mq.pop_front() << (4 * i));
    e_cnt = 2'(k);
    e_en  = 1'b1;
  endtask

  task automatic model(bit s, logic [7:0] d, logic [1:0] c, bit f);
    int n;
    e_en = 1'b0;
    if (mpend) begin
      mpend = 1'b0;
      if (mq.size() > 0) emit(mq.size());
      return;
    end
    if (s) begin
      n = (c > 2) ? 2 : int'(c);
      for (int i = 0; i < n; i++) mq.push_back((d >> (4 * i)) & 8'hF);
    end
    if (f && mq.size() <= 2) begin
      if (mq.size() > 0) emit(mq.size());
    end else if (mq.size() >= 2) begin
      emit(2);
      if (f) mpend = 1'b1;
    end
  endtask

  task automatic step(bit s, logic [7:0] d, logic [1:0] c, bit f);
    a.start = s; a.data_in = d; a.cnt = c; a.flush = f;
    model(s, d, c, f);
    @(posedge clk); #1;
    chk("data_en",  a.data_en,  e_en);
    chk("data_cnt", a.data_cnt, e_cnt);
    chk("data_o",   a.data_o,   e_do);
    chk("res_cnt",  a.res_cnt,  mq.size());
    chk("ready",    a.ready,    !mpend);
  endtask

  task automatic do_reset();
    a.start = 0; a.flush = 0; a.cnt = 0; a.data_in = 0;
    b.start = 0; b.flush = 0; b.cnt = 0; b.data_in = 0;
    reset = 1'b1;
    #1;
    chk("rst_data_o",   a.data_o,   0);
    chk("rst_data_en",  a.data_en,  0);
    chk("rst_data_cnt", a.data_cnt, 0);
    chk("rst_res_cnt",  a.res_cnt,  0);
    chk("rst_ready",    a.ready,    1);
    chk("rst_b_data_o", b.data_o,   0);
    mq.delete(); mpend = 0; e_do = 0; e_cnt = 0; e_en = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s, f;
    logic [7:0] d;
    logic [1:0] c;
    reset = 1'b1;
    do_reset();

    // Packing sequence with a gap and don't-care upper nibbles
    step(1, 8'h10, 2, 0);
    chk("seq_w0", a.data_o, 8'h10);
    step(1, 8'hF2, 1, 0);
    step(0, 8'hAA, 2, 0);
    step(1, 8'h43, 2, 0);
    chk("seq_w1", a.data_o, 8'h32);
    step(1, 8'h95, 2, 0);
    step(1, 8'hE6, 1, 0);
    chk("seq_w3", a.data_o, 8'h69);
    step(1, 8'h87, 2, 0);
    chk("seq_res", a.res_cnt, 0);

    // Flush alone emits held single unit
    step(1, 8'hC2, 1, 0);
    step(0, 8'h00, 0, 1);
    chk("flush_w", a.data_o, 8'h02);
    chk("flush_c", a.data_cnt, 1);

    // Overflowing flush: full word, then remainder with ready low
    step(1, 8'h52, 1, 0);
    step(1, 8'h43, 2, 1);
    chk("ovf_w0", a.data_o, 8'h32);
    chk("ovf_rdy", a.ready, 0);
    step(1, 8'h43, 2, 1);
    chk("ovf_w1", a.data_o, 8'h04);
    chk("ovf_c1", a.data_cnt, 1);

    // Clamped count and zero count
    step(1, 8'hAB, 3, 0);
    chk("clamp_w", a.data_o, 8'hAB);
    step(1, 8'h07, 1, 0);
    step(1, 8'h55, 0, 0);
    chk("cnt0_en", a.data_en, 0);
    chk("cnt0_res", a.res_cnt, 1);

    // Reset with residue held, then flush must find nothing
    do_reset();
    step(0, 8'h00, 0, 1);
    // Reset while a remainder is pending
    step(1, 8'h01, 1, 0);
    step(1, 8'h32, 2, 1);
    do_reset();
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);

    // Four-unit word: cnt 3,3,2
    b.start = 1; b.data_in = 16'h0321; b.cnt = 3;
    step(0, 8'h00, 0, 0);
    chk("b_en0", b.data_en, 0);
    chk("b_res0", b.res_cnt, 3);
    b.data_in = 16'h0654; b.cnt = 3;
    step(0, 8'h00, 0, 0);
    chk("b_en1", b.data_en, 1);
    chk("b_w1", b.data_o, 16'h4321);
    chk("b_c1", b.data_cnt, 4);
    b.data_in = 16'h0087; b.cnt = 2;
    step(0, 8'h00, 0, 0);
    chk("b_w2", b.data_o, 16'h8765);
    chk("b_res2", b.res_cnt, 0);
    b.start = 0;

    // Random traffic; inputs are held while the model expects ready low
    s = 0; d = 0; c = 0; f = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mpend) begin
        s = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
        c = 2'($urandom_range(0, 3));
        f = ($urandom_range(0, 4) == 0);
      end
      step(s, d, c, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
